// File: rtl/id_ex_operand_if.sv
// Bundle of the ID/EX operand stage signals: decode side, forwarding
// sources, and the ALU-facing outputs. The master side drives decode,
// forwarding and downstream-ready. The slave side is the stage itself.
interface id_ex_operand_if #(
    parameter int XLEN   = 32,
    parameter int RA_W   = 5,
    parameter int CTRL_W = 4
);
    logic              flush;
    logic              id_valid;
    logic              id_ready;
    logic [XLEN-1:0]   id_pc;
    logic [XLEN-1:0]   id_rs1_data;
    logic [XLEN-1:0]   id_rs2_data;
    logic [XLEN-1:0]   id_imm;
    logic [RA_W-1:0]   id_rs1;
    logic [RA_W-1:0]   id_rs2;
    logic [RA_W-1:0]   id_rd;
    logic [CTRL_W-1:0] id_alu_ctrl;
    logic              id_a_sel;
    logic              id_b_sel;
    logic              id_reg_write;
    logic              id_mem_read;
    logic [RA_W-1:0]   mem_rd;
    logic              mem_reg_write;
    logic [XLEN-1:0]   mem_result;
    logic [RA_W-1:0]   wb_rd;
    logic              wb_reg_write;
    logic [XLEN-1:0]   wb_result;
    logic              ex_valid;
    logic              ex_ready;
    logic [XLEN-1:0]   SrcA;
    logic [XLEN-1:0]   SrcB;
    logic [CTRL_W-1:0] ALU_Ctrl;
    logic [XLEN-1:0]   ex_store_data;
    logic [XLEN-1:0]   ex_pc;
    logic [RA_W-1:0]   ex_rd;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              load_use_stall;

    modport master (
        output flush, id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, id_alu_ctrl, id_a_sel, id_b_sel,
               id_reg_write, id_mem_read,
               mem_rd, mem_reg_write, mem_result,
               wb_rd, wb_reg_write, wb_result, ex_ready,
        input  id_ready, ex_valid, SrcA, SrcB, ALU_Ctrl, ex_store_data,
               ex_pc, ex_rd, ex_reg_write, ex_mem_read, load_use_stall
    );

    modport slave (
        input  flush, id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, id_alu_ctrl, id_a_sel, id_b_sel,
               id_reg_write, id_mem_read,
               mem_rd, mem_reg_write, mem_result,
               wb_rd, wb_reg_write, wb_result, ex_ready,
        output id_ready, ex_valid, SrcA, SrcB, ALU_Ctrl, ex_store_data,
               ex_pc, ex_rd, ex_reg_write, ex_mem_read, load_use_stall
    );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register feeding the ALU. Holds decoded operands and
// control, resolves EX/MEM and MEM/WB forwarding on the stored source
// indices, and raises a load-use stall so the consumer of a load waits
// one bubble and then picks the value up from WB.
module id_ex_operand_stage #(
    parameter int XLEN   = 32,
    parameter int RA_W   = 5,
    parameter int CTRL_W = 4
) (
    input logic            clk,
    input logic            rst,
    id_ex_operand_if.slave bus
);
    logic              vld_p1;
    logic [XLEN-1:0]   pc_p1;
    logic [XLEN-1:0]   rs1_data_p1;
    logic [XLEN-1:0]   rs2_data_p1;
    logic [XLEN-1:0]   imm_p1;
    logic [RA_W-1:0]   rs1_p1;
    logic [RA_W-1:0]   rs2_p1;
    logic [RA_W-1:0]   rd_p1;
    logic [CTRL_W-1:0] alu_ctrl_p1;
    logic              a_sel_p1;
    logic              b_sel_p1;
    logic              reg_write_p1;
    logic              mem_read_p1;

    logic              advance;
    logic              stall;
    logic [XLEN-1:0]   fwd_a;
    logic [XLEN-1:0]   fwd_b;

    // MEM is the younger producer, so it wins over WB; x0 is hardwired zero
    // and must never pick up a forwarded value.
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [RA_W-1:0] idx,
        input logic [XLEN-1:0] stored,
        input logic            m_we,
        input logic [RA_W-1:0] m_rd,
        input logic [XLEN-1:0] m_res,
        input logic            w_we,
        input logic [RA_W-1:0] w_rd,
        input logic [XLEN-1:0] w_res
    );
        if (m_we && (m_rd != '0) && (m_rd == idx))
            return m_res;
        else if (w_we && (w_rd != '0) && (w_rd == idx))
            return w_res;
        else
            return stored;
    endfunction

    // Handshake, load-use detection and operand forwarding
    always_comb begin
        advance = ~vld_p1 | bus.ex_ready;
        stall   = vld_p1 & mem_read_p1 & (rd_p1 != '0) & bus.id_valid &
                  ((bus.id_rs1 == rd_p1) | (~bus.id_b_sel & (bus.id_rs2 == rd_p1)));
        fwd_a   = fwd_sel(rs1_p1, rs1_data_p1, bus.mem_reg_write, bus.mem_rd,
                          bus.mem_result, bus.wb_reg_write, bus.wb_rd, bus.wb_result);
        fwd_b   = fwd_sel(rs2_p1, rs2_data_p1, bus.mem_reg_write, bus.mem_rd,
                          bus.mem_result, bus.wb_reg_write, bus.wb_rd, bus.wb_result);
    end

    // ---- ID -> EX register boundary ----
    // Stage register: reset, flush, load, bubble, or hold with operand refresh
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1       <= 1'b0;
            pc_p1        <= '0;
            rs1_data_p1  <= '0;
            rs2_data_p1  <= '0;
            imm_p1       <= '0;
            rs1_p1       <= '0;
            rs2_p1       <= '0;
            rd_p1        <= '0;
            alu_ctrl_p1  <= '0;
            a_sel_p1     <= 1'b0;
            b_sel_p1     <= 1'b0;
            reg_write_p1 <= 1'b0;
            mem_read_p1  <= 1'b0;
        end else if (bus.flush) begin
            vld_p1 <= 1'b0;
        end else if (advance && bus.id_valid && !stall) begin
            vld_p1       <= 1'b1;
            pc_p1        <= bus.id_pc;
            rs1_data_p1  <= bus.id_rs1_data;
            rs2_data_p1  <= bus.id_rs2_data;
            imm_p1       <= bus.id_imm;
            rs1_p1       <= bus.id_rs1;
            rs2_p1       <= bus.id_rs2;
            rd_p1        <= bus.id_rd;
            alu_ctrl_p1  <= bus.id_alu_ctrl;
            a_sel_p1     <= bus.id_a_sel;
            b_sel_p1     <= bus.id_b_sel;
            reg_write_p1 <= bus.id_reg_write;
            mem_read_p1  <= bus.id_mem_read;
        end else if (advance) begin
            vld_p1 <= 1'b0;
        end else begin
            // Held instruction: capture forwarded values now, since the
            // producer may retire from WB before the hold ends.
            rs1_data_p1 <= fwd_a;
            rs2_data_p1 <= fwd_b;
        end
    end

    assign bus.id_ready       = advance & ~stall & ~bus.flush;
    assign bus.load_use_stall = stall;
    assign bus.ex_valid       = vld_p1;
    assign bus.SrcA           = a_sel_p1 ? pc_p1 : fwd_a;
    assign bus.SrcB           = b_sel_p1 ? imm_p1 : fwd_b;
    assign bus.ex_store_data  = fwd_b;
    assign bus.ALU_Ctrl       = alu_ctrl_p1;
    assign bus.ex_pc          = pc_p1;
    assign bus.ex_rd          = rd_p1;
    assign bus.ex_reg_write   = reg_write_p1;
    assign bus.ex_mem_read    = mem_read_p1;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for the ID/EX operand stage: reset, forwarding priority,
// x0 guard, load-use bubble, hold-time operand refresh and flush.
module tb_id_ex_operand_stage;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    id_ex_operand_if #(.XLEN(32), .RA_W(5), .CTRL_W(4)) bus ();

    id_ex_operand_stage #(.XLEN(32), .RA_W(5), .CTRL_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow a settle delay.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_fwd();
        bus.mem_rd = '0; bus.mem_reg_write = 1'b0; bus.mem_result = '0;
        bus.wb_rd  = '0; bus.wb_reg_write  = 1'b0; bus.wb_result  = '0;
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc, input logic [31:0] r1d,
                          input logic [31:0] r2d, input logic [31:0] imm,
                          input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                          input logic [3:0] ctrl, input logic as, input logic bs,
                          input logic rw, input logic mr);
        bus.id_valid = v; bus.id_pc = pc; bus.id_rs1_data = r1d; bus.id_rs2_data = r2d;
        bus.id_imm = imm; bus.id_rs1 = r1; bus.id_rs2 = r2; bus.id_rd = rd;
        bus.id_alu_ctrl = ctrl; bus.id_a_sel = as; bus.id_b_sel = bs;
        bus.id_reg_write = rw; bus.id_mem_read = mr;
    endtask

    initial begin
        rst = 1'b1;
        bus.flush = 1'b0;
        bus.ex_ready = 1'b1;
        clear_fwd();
        set_id(1'b0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b0;
        #1;

        // Reset state
        chk("rst_ex_valid", bus.ex_valid, 0);
        chk("rst_alu_ctrl", bus.ALU_Ctrl, 0);
        chk("rst_reg_write", bus.ex_reg_write, 0);
        chk("rst_mem_read", bus.ex_mem_read, 0);
        chk("rst_srca", bus.SrcA, 0);
        chk("rst_id_ready", bus.id_ready, 1);

        // Plain accept, then forwarding priority on the stored rs1=5
        set_id(1'b1, 32'h100, 32'h55, 32'h66, 32'h10, 5'd5, 5'd6, 5'd7, 4'h2, 0, 0, 1, 0);
        #1;
        chk("acc_id_ready", bus.id_ready, 1);
        tick();
        bus.id_valid = 1'b0;
        #1;
        chk("acc_ex_valid", bus.ex_valid, 1);
        chk("acc_alu_ctrl", bus.ALU_Ctrl, 4'h2);
        chk("acc_ex_pc", bus.ex_pc, 32'h100);
        chk("acc_ex_rd", bus.ex_rd, 7);
        chk("acc_ex_reg_write", bus.ex_reg_write, 1);
        chk("acc_srca", bus.SrcA, 32'h55);
        chk("acc_srcb", bus.SrcB, 32'h66);
        bus.mem_rd = 5'd5; bus.mem_reg_write = 1'b1; bus.mem_result = 32'h11;
        bus.wb_rd  = 5'd5; bus.wb_reg_write  = 1'b1; bus.wb_result  = 32'h22;
        #1;
        chk("fwd_mem_prio", bus.SrcA, 32'h11);
        bus.mem_reg_write = 1'b0;
        #1;
        chk("fwd_wb", bus.SrcA, 32'h22);
        bus.wb_rd = 5'd6; bus.wb_result = 32'h77;
        #1;
        chk("fwd_b_srcb", bus.SrcB, 32'h77);
        chk("fwd_b_store", bus.ex_store_data, 32'h77);
        chk("fwd_b_srca_unfwd", bus.SrcA, 32'h55);
        clear_fwd();

        // x0 guard; b_sel picks the immediate over a forwarded rs2
        set_id(1'b1, 32'h104, 32'h0, 32'h33, 32'h20, 5'd0, 5'd9, 5'd1, 4'h1, 0, 1, 1, 0);
        tick();
        bus.id_valid = 1'b0;
        bus.mem_rd = 5'd0; bus.mem_reg_write = 1'b1; bus.mem_result = 32'hFF;
        bus.wb_rd  = 5'd9; bus.wb_reg_write  = 1'b1; bus.wb_result  = 32'h99;
        #1;
        chk("x0_guard_srca", bus.SrcA, 32'h0);
        chk("bsel_imm_srcb", bus.SrcB, 32'h20);
        chk("bsel_store_fwd", bus.ex_store_data, 32'h99);
        clear_fwd();

        // Reset while holding a live instruction
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_ex_valid", bus.ex_valid, 0);
        chk("midrst_alu_ctrl", bus.ALU_Ctrl, 0);
        chk("midrst_ex_pc", bus.ex_pc, 0);

        // Load-use: lw x3 in EX, add x4,x3,x1 at ID
        set_id(1'b1, 32'h200, 32'h1000, 32'h0, 32'h8, 5'd2, 5'd0, 5'd3, 4'h0, 0, 1, 1, 1);
        tick();
        set_id(1'b1, 32'h204, 32'hDEAD, 32'h5, 32'h0, 5'd3, 5'd1, 5'd4, 4'h0, 0, 0, 1, 0);
        #1;
        chk("lu_stall", bus.load_use_stall, 1);
        chk("lu_id_ready", bus.id_ready, 0);
        chk("lu_ex_mem_read", bus.ex_mem_read, 1);
        tick();
        chk("lu_bubble", bus.ex_valid, 0);
        chk("lu_stall_clear", bus.load_use_stall, 0);
        chk("lu_id_ready_again", bus.id_ready, 1);
        tick();
        bus.id_valid = 1'b0;
        bus.wb_rd = 5'd3; bus.wb_reg_write = 1'b1; bus.wb_result = 32'hCAFE;
        #1;
        chk("lu_add_valid", bus.ex_valid, 1);
        chk("lu_add_srca", bus.SrcA, 32'hCAFE);
        chk("lu_add_srcb", bus.SrcB, 32'h5);
        chk("lu_add_rd", bus.ex_rd, 4);
        clear_fwd();

        // Hold for 3 cycles; WB value for rs2=7 appears only in the first
        set_id(1'b1, 32'h300, 32'h1, 32'h1111, 32'h0, 5'd8, 5'd7, 5'd9, 4'h3, 0, 0, 1, 0);
        tick();
        bus.id_valid = 1'b0;
        bus.ex_ready = 1'b0;
        bus.wb_rd = 5'd7; bus.wb_reg_write = 1'b1; bus.wb_result = 32'hABCD;
        #1;
        chk("hold_id_ready", bus.id_ready, 0);
        tick();
        clear_fwd();
        tick();
        tick();
        #1;
        chk("hold_ex_valid", bus.ex_valid, 1);
        chk("hold_refresh_srcb", bus.SrcB, 32'hABCD);
        chk("hold_refresh_store", bus.ex_store_data, 32'hABCD);

        // Flush while downstream is stalled and ID offers an instruction
        set_id(1'b1, 32'h400, 32'h2, 32'h3, 32'h0, 5'd1, 5'd2, 5'd10, 4'h5, 0, 0, 1, 0);
        bus.flush = 1'b1;
        #1;
        chk("flush_id_ready", bus.id_ready, 0);
        tick();
        bus.flush = 1'b0;
        bus.id_valid = 1'b0;
        #1;
        chk("flush_ex_valid", bus.ex_valid, 0);
        chk("flush_not_loaded", bus.ALU_Ctrl, 4'h3);
        bus.ex_ready = 1'b1;

        // a_sel/b_sel pick PC and immediate, then a bubble
        set_id(1'b1, 32'h500, 32'h7, 32'h8, 32'h44, 5'd1, 5'd2, 5'd11, 4'h6, 1, 1, 0, 0);
        tick();
        bus.id_valid = 1'b0;
        #1;
        chk("asel_srca_pc", bus.SrcA, 32'h500);
        chk("bsel_srcb_imm", bus.SrcB, 32'h44);
        chk("asel_reg_write", bus.ex_reg_write, 0);
        tick();
        chk("bubble_ex_valid", bus.ex_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
